// File: rtl/delay_step_sequencer.sv
// delay_step_sequencer
// Buffers (byte, delay) steps in a small FIFO and plays them out one at a
// time: present the byte, request a delay from the interrupt controller,
// then block until the completion pulse or the millisecond watchdog fires.
module delay_step_sequencer #(
    parameter int unsigned MFREQ_KHZ = 1,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MARGIN_MS = 2
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic [15:0] in_delay_ms,
    output logic [7:0]  data_out,
    output logic        data_strobe,
    output logic        raise_interrupt,
    output logic [15:0] delay_ms,
    input  logic        interrupt,
    output logic        step_done,
    output logic        timeout_err,
    input  logic        err_clear,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = (MFREQ_KHZ > 1) ? $clog2(MFREQ_KHZ) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [PW-1:0] PRE_MAX  = PW'(MFREQ_KHZ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_REQ   = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    // FIFO storage: each entry is {delay, data}
    logic [23:0]   mem_q [DEPTH];
    logic [23:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    state_t        state_q, state_d;
    logic [7:0]    lat_data_q, lat_data_d;
    logic [15:0]   lat_delay_q, lat_delay_d;
    logic [7:0]    data_out_q, data_out_d;
    logic [15:0]   delay_ms_q, delay_ms_d;
    logic          data_strobe_q, data_strobe_d;
    logic          raise_q, raise_d;
    logic          step_done_q, step_done_d;
    logic          timeout_err_q, timeout_err_d;
    logic          err_set_s;
    logic [PW-1:0] pre_q, pre_d;
    logic [16:0]   ms_q, ms_d;

    logic full_s, empty_s, push_s, pop_s, expiry_s;

    assign full_s   = (count_q == FULL_CNT);
    assign empty_s  = (count_q == '0);
    assign push_s   = in_valid && !full_s;
    assign pop_s    = (state_q == S_IDLE) && !empty_s;
    // 17-bit sum so delay + margin never wraps
    assign expiry_s = (ms_q == ({1'b0, delay_ms_q} + 17'(MARGIN_MS)));

    assign in_ready        = !full_s;
    assign busy            = !empty_s || (state_q != S_IDLE);
    assign data_out        = data_out_q;
    assign delay_ms        = delay_ms_q;
    assign data_strobe     = data_strobe_q;
    assign raise_interrupt = raise_q;
    assign step_done       = step_done_q;
    assign timeout_err     = timeout_err_q;

    // FIFO next-state: write at tail on push, advance head on pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {in_delay_ms, in_data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Step sequencer FSM, output pulses and watchdog counters
    always_comb begin
        state_d       = state_q;
        lat_data_d    = lat_data_q;
        lat_delay_d   = lat_delay_q;
        data_out_d    = data_out_q;
        delay_ms_d    = delay_ms_q;
        data_strobe_d = 1'b0;
        raise_d       = 1'b0;
        step_done_d   = 1'b0;
        pre_d         = pre_q;
        ms_d          = ms_q;
        err_set_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_s) begin
                    lat_data_d  = mem_q[rd_ptr_q][7:0];
                    lat_delay_d = mem_q[rd_ptr_q][23:8];
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                data_out_d    = lat_data_q;
                delay_ms_d    = lat_delay_q;
                data_strobe_d = 1'b1;
                if (lat_delay_q == 16'd0) begin
                    step_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                raise_d = 1'b1;
                pre_d   = '0;
                ms_d    = 17'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion that coincides with expiry is a normal finish
                if (interrupt) begin
                    step_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (expiry_s) begin
                    err_set_s   = 1'b1;
                    step_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    ms_d  = ms_q + 17'd1;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky error flag; a new timeout wins over a simultaneous clear
    always_comb begin
        if (err_set_s) begin
            timeout_err_d = 1'b1;
        end else if (err_clear) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // State, FIFO and output registers with asynchronous reset
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 24'd0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            lat_data_q    <= 8'd0;
            lat_delay_q   <= 16'd0;
            data_out_q    <= 8'd0;
            delay_ms_q    <= 16'd0;
            data_strobe_q <= 1'b0;
            raise_q       <= 1'b0;
            step_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            pre_q         <= '0;
            ms_q          <= 17'd0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            lat_data_q    <= lat_data_d;
            lat_delay_q   <= lat_delay_d;
            data_out_q    <= data_out_d;
            delay_ms_q    <= delay_ms_d;
            data_strobe_q <= data_strobe_d;
            raise_q       <= raise_d;
            step_done_q   <= step_done_d;
            timeout_err_q <= timeout_err_d;
            pre_q         <= pre_d;
            ms_q          <= ms_d;
        end
    end

endmodule

// File: tb/tb_delay_step_sequencer.sv
// Bench for delay_step_sequencer: directed scenarios plus random steps.
// Stimulus pushes expected steps into a queue; a monitor acting as the
// interrupt controller pops and checks each presented step and its timing.
module tb_delay_step_sequencer;

    localparam int MF = 4;
    localparam int DP = 4;
    localparam int MG = 2;

    logic        mclk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [15:0] in_delay_ms;
    logic [7:0]  data_out;
    logic        data_strobe;
    logic        raise_interrupt;
    logic [15:0] delay_ms;
    logic        interrupt;
    logic        step_done;
    logic        timeout_err;
    logic        err_clear;
    logic        busy;

    delay_step_sequencer #(.MFREQ_KHZ(MF), .DEPTH(DP), .MARGIN_MS(MG)) dut (
        .mclk(mclk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_delay_ms(in_delay_ms),
        .data_out(data_out), .data_strobe(data_strobe),
        .raise_interrupt(raise_interrupt), .delay_ms(delay_ms),
        .interrupt(interrupt), .step_done(step_done),
        .timeout_err(timeout_err), .err_clear(err_clear), .busy(busy)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    // lat: cycles from the visible request to our interrupt pulse; 0 = withhold
    typedef struct {
        logic [7:0]  data;
        logic [15:0] dly;
        int          lat;
    } step_t;

    step_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    logic  stray_req = 1'b0;
    bit    mon_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor + interrupt-controller model
    step_t cur;
    int    strobe_cyc;
    int    exp_done = -1;
    int    int_at = -1;
    bit    model_err = 1'b0;
    bit    clr_pend = 1'b0;
    bit    exp_raise, done_exp, set_err;

    initial begin
        interrupt = 1'b0;
        forever begin
            @(negedge mclk);
            #1;
            if (rst) begin
                exp_q.delete();
                mon_active = 1'b0;
                exp_done   = -1;
                int_at     = -1;
                model_err  = 1'b0;
                clr_pend   = 1'b0;
                interrupt  = 1'b0;
                continue;
            end
            if (data_strobe) begin
                check("strobe_has_step", 32'(exp_q.size() != 0), 32'd1);
                check("strobe_overlap", 32'(mon_active), 32'd0);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("data_out", 32'(data_out), 32'(cur.data));
                    check("delay_ms", 32'(delay_ms), 32'(cur.dly));
                    mon_active = 1'b1;
                    strobe_cyc = cyc;
                    exp_done   = (cur.dly == 16'd0) ? cyc : -1;
                    int_at     = -1;
                end
            end
            exp_raise = mon_active && (cur.dly != 16'd0) && (cyc == strobe_cyc + 1);
            if (raise_interrupt || exp_raise) begin
                check("raise_interrupt", 32'(raise_interrupt), 32'(exp_raise));
                if (exp_raise) begin
                    check("delay_ms_at_req", 32'(delay_ms), 32'(cur.dly));
                    int_at   = (cur.lat > 0) ? cyc + cur.lat - 1 : -1;
                    // watchdog notices (delay + margin) ms on the following cycle
                    exp_done = (cur.lat > 0) ? cyc + cur.lat
                                             : cyc + MF * (int'(cur.dly) + MG) + 1;
                end
            end
            done_exp = mon_active && (exp_done >= 0) && (cyc == exp_done);
            if (step_done || done_exp) begin
                check("step_done", 32'(step_done), 32'(done_exp));
            end
            set_err = done_exp && (cur.dly != 16'd0) && (cur.lat == 0);
            if (done_exp) mon_active = 1'b0;
            model_err = set_err ? 1'b1 : (clr_pend ? 1'b0 : model_err);
            clr_pend  = err_clear;
            check("timeout_err", 32'(timeout_err), 32'(model_err));
            interrupt = (mon_active && (cyc == int_at)) || stray_req;
        end
    end

    task automatic push_step(input logic [7:0] d, input logic [15:0] dl, input int lat);
        int waited = 0;
        @(negedge mclk);
        in_valid    = 1'b1;
        in_data     = d;
        in_delay_ms = dl;
        while (!in_ready && waited < 300) begin
            @(negedge mclk);
            waited++;
        end
        check("push_accepted", 32'(in_ready), 32'd1);
        if (in_ready) begin
            exp_q.push_back(step_t'{d, dl, lat});
            @(posedge mclk);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        @(negedge mclk);
        in_valid = 1'b0;
    endtask

    task automatic wait_raise();
        int n = 0;
        while (!raise_interrupt && n < 50) begin
            @(negedge mclk);
            n++;
        end
        check("raise_seen", 32'(raise_interrupt), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        @(negedge mclk);
        while ((busy || exp_q.size() != 0 || mon_active) && n < 2000) begin
            @(negedge mclk);
            n++;
        end
        check(name, 32'(busy || exp_q.size() != 0 || mon_active), 32'd0);
    endtask

    task automatic stray_pulse();
        @(negedge mclk);
        stray_req = 1'b1;
        @(negedge mclk);
        stray_req = 1'b0;
        repeat (3) @(negedge mclk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
        check({tag, "_delay_ms"}, 32'(delay_ms), 32'd0);
        check({tag, "_strobe"}, 32'(data_strobe), 32'd0);
        check({tag, "_raise"}, 32'(raise_interrupt), 32'd0);
        check({tag, "_step_done"}, 32'(step_done), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit");
    end

    // Stimulus
    initial begin
        int w, r, lat;
        logic [15:0] dl;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_delay_ms = 16'd0; err_clear = 1'b0;

        // reset and idle behaviour
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        check_reset_values("rst_hold");
        rst = 1'b0;
        stray_pulse();
        check_reset_values("idle_stray");

        // single step with returned interrupt, then a zero-delay step
        push_step(8'h38, 16'd5, 20);
        push_step(8'h01, 16'd0, 0);
        idle_inputs();
        wait_drain("drain_single");
        check("single_last_byte", 32'(data_out), 32'h01);
        check("single_busy", 32'(busy), 32'd0);

        // FIFO fill and backpressure while the first step waits
        push_step(8'h38, 16'd5, 20);
        idle_inputs();
        wait_raise();
        push_step(8'h0C, 16'd1, 3);
        push_step(8'h06, 16'd1, 3);
        push_step(8'h01, 16'd1, 3);
        push_step(8'h80, 16'd1, 3);
        @(negedge mclk);
        in_valid = 1'b0;
        check("fifo_full_in_ready", 32'(in_ready), 32'd0);
        check("fifo_full_busy", 32'(busy), 32'd1);
        push_step(8'h55, 16'd0, 0);
        idle_inputs();
        wait_drain("drain_fifo");

        // watchdog timeout, next step proceeds, clear
        push_step(8'hA5, 16'd3, 0);
        push_step(8'h11, 16'd0, 0);
        idle_inputs();
        wait_drain("drain_timeout");
        check("timeout_sticky", 32'(timeout_err), 32'd1);
        err_clear = 1'b1;
        @(negedge mclk);
        err_clear = 1'b0;
        check("timeout_cleared", 32'(timeout_err), 32'd0);

        // timeout with err_clear held: set must win on the expiry edge
        @(negedge mclk);
        err_clear = 1'b1;
        push_step(8'hB6, 16'd1, 0);
        idle_inputs();
        wait_drain("drain_prio");
        err_clear = 1'b0;

        // interrupt coinciding with expiry is a normal completion
        push_step(8'hC7, 16'd2, MF * (2 + MG) + 1);
        idle_inputs();
        wait_drain("drain_coincide");

        // asynchronous reset in the middle of WAIT
        push_step(8'h77, 16'd10, 0);
        push_step(8'h78, 16'd2, 3);
        idle_inputs();
        wait_raise();
        repeat (5) @(negedge mclk);
        @(posedge mclk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge mclk);
        @(negedge mclk);
        rst = 1'b0;
        stray_pulse();
        check_reset_values("late_int");
        push_step(8'h99, 16'd1, 2);
        idle_inputs();
        wait_drain("drain_after_rst");
        check("after_rst_byte", 32'(data_out), 32'h99);

        // randomized steps
        for (int i = 0; i < 30; i++) begin
            dl  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
            w   = MF * (int'(dl) + MG) + 1;
            r   = $urandom_range(0, 9);
            lat = (r == 0) ? 0 : ((r == 1) ? w : $urandom_range(1, w - 1));
            push_step(8'($urandom), dl, lat);
            if ($urandom_range(0, 2) == 0) begin
                @(negedge mclk);
                in_valid  = 1'b0;
                err_clear = ($urandom_range(0, 4) == 0);
                repeat ($urandom_range(0, 5)) @(negedge mclk);
                err_clear = 1'b0;
            end
        end
        idle_inputs();
        wait_drain("drain_random");
        check("final_busy", 32'(busy), 32'd0);

        repeat (3) @(negedge mclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
